// File: rtl/router_pkt_tx.sv
// Router input-side packet transmitter: buffers a payload from the source, then
// sends header, payload and parity to the router under busy back-pressure.
module router_pkt_tx #(
    parameter int unsigned CHECK_CYCLES = 3,
    parameter int unsigned IDLE_GAP     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       busy,
    input  logic       err,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       reject,
    output logic       done,
    output logic       pkt_err
);
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 6;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEPTH = 64;

    localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_CHECK,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    dest_q, dest_d;
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [DW-1:0] par_q, par_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sticky_q, sticky_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          tx_busy_q, tx_busy_d;
    logic          reject_q, reject_d;
    logic          done_q, done_d;
    logic          pkt_err_q, pkt_err_d;
    logic          mem_we;
    logic [DW-1:0] mem_q [DEPTH];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        par_d       = par_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        pkt_valid_d = pkt_valid_q;
        pkt_err_d   = pkt_err_q;
        reject_d    = 1'b0;
        done_d      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dest == 2'd3 || len == '0) begin
                        reject_d = 1'b1;
                    end else begin
                        dest_d  = dest;
                        len_d   = len;
                        par_d   = {len, dest};
                        wptr_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (src_valid) begin
                    mem_we = 1'b1;
                    par_d  = par_q ^ src_data;
                    if (wptr_q == len_q - PW'(1)) begin
                        state_d     = S_HEADER;
                        data_d      = {len_q, dest_q};
                        pkt_valid_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + PW'(1);
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d = S_PAYLOAD;
                    data_d  = mem_q[0];
                    rptr_d  = '0;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (rptr_q == len_q - PW'(1)) begin
                        state_d     = S_PARITY;
                        data_d      = par_q;
                        pkt_valid_d = 1'b0;
                    end else begin
                        rptr_d = rptr_q + PW'(1);
                        data_d = mem_q[rptr_q + PW'(1)];
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d  = S_CHECK;
                    data_d   = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            S_CHECK: begin
                if (cnt_q == CHK_LAST) begin
                    done_d    = 1'b1;
                    pkt_err_d = sticky_q | err;
                    cnt_d     = '0;
                    state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    sticky_d = sticky_q | err;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            par_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            pkt_valid_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            reject_q    <= 1'b0;
            done_q      <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            par_q       <= par_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            pkt_valid_q <= pkt_valid_d;
            tx_busy_q   <= tx_busy_d;
            reject_q    <= reject_d;
            done_q      <= done_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    // Payload buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= src_data;
        end
    end

    assign src_ready = (state_q == S_LOAD);
    assign data_in   = data_q;
    assign pkt_valid = pkt_valid_q;
    assign tx_busy   = tx_busy_q;
    assign reject    = reject_q;
    assign done      = done_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packet scenarios plus hand-written
// reject and mid-packet reset sequences.
module tb_router_pkt_tx;
    logic       clk;
    logic       resetn;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic       err;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       tx_busy;
    logic       reject;
    logic       done;
    logic       pkt_err;

    int nvec = 0;
    int nerr = 0;

    router_pkt_tx #(.CHECK_CYCLES(3), .IDLE_GAP(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .busy      (busy),
        .err       (err),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .tx_busy   (tx_busy),
        .reject    (reject),
        .done      (done),
        .pkt_err   (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // err_mode: 0 none, 1 asserted during payload, 2 asserted on 2nd CHECK cycle
    typedef struct {
        logic [1:0] dest;
        logic [5:0] len;
        logic [7:0] base;
        logic [7:0] step;
        bit         thr;
        int         busy_at;
        int         busy_n;
        int         err_mode;
        logic [7:0] hdr;
        logic [7:0] par;
        bit         perr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input vec_t v, input int i);
        return 8'(v.base + v.step * 8'(i));
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int L;
        int n;
        int wk;
        int idx;
        int stall;
        int guard;
        bit tog;
        bit pv;
        logic [7:0] e;
        L = int'(v.len);
        n = L + 2;

        chk($sformatf("v%0d_idle_ready", id), {8'h0, src_ready}, 9'h0);
        dest = v.dest; len = v.len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_start_ready", id), {7'h0, tx_busy, src_ready}, 9'h3);

        wk = 0; tog = 1'b1; guard = 0;
        while (wk < L && guard < 400) begin
            chk($sformatf("v%0d_load_ready", id), {8'h0, src_ready}, 9'h1);
            if (!v.thr || tog) begin
                src_valid = 1'b1; src_data = pat(v, wk); wk++;
            end else begin
                src_valid = 1'b0;
            end
            tog = ~tog;
            @(negedge clk);
            guard++;
        end
        src_valid = 1'b0;
        chk($sformatf("v%0d_load_bound", id), {8'h0, guard < 400}, 9'h1);
        chk($sformatf("v%0d_hdr_latency", id), {pkt_valid, data_in}, {1'b1, v.hdr});
        chk($sformatf("v%0d_ready_drop", id), {8'h0, src_ready}, 9'h0);

        idx = 0; stall = 0; guard = 0;
        while (idx < n && guard < 400) begin
            e  = (idx == 0) ? v.hdr : (idx == n - 1) ? v.par : pat(v, idx - 1);
            pv = (idx < n - 1);
            chk($sformatf("v%0d_stream%0d", id, idx), {pkt_valid, data_in}, {pv, e});
            err = (v.err_mode == 1) && idx >= 1 && idx <= L;
            if (idx == v.busy_at && stall < v.busy_n) begin
                busy = 1'b1; stall++;
            end else begin
                busy = 1'b0; idx++;
            end
            @(negedge clk);
            guard++;
        end
        busy = 1'b0; err = 1'b0;
        chk($sformatf("v%0d_stream_bound", id), {8'h0, guard < 400}, 9'h1);
        chk($sformatf("v%0d_accepted", id), 9'(guard - stall), 9'(n));

        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("v%0d_done_k%0d", id, k), {8'h0, done}, {8'h0, k == 3});
            chk($sformatf("v%0d_quiet_k%0d", id, k), {pkt_valid, data_in}, 9'h0);
            chk($sformatf("v%0d_txbusy_k%0d", id, k), {8'h0, tx_busy}, {8'h0, k < 5});
            if (k >= 3) chk($sformatf("v%0d_pkterr_k%0d", id, k), {8'h0, pkt_err}, {8'h0, v.perr});
            err = (v.err_mode == 2) && k == 1;
            if (k < 5) @(negedge clk);
        end
        err = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd1, 6'd3,  8'h11, 8'h11, 1'b0, -1, 0, 0, 8'h0D, 8'h0D, 1'b0};
        vecs[1] = '{2'd1, 6'd3,  8'h11, 8'h11, 1'b0,  2, 4, 0, 8'h0D, 8'h0D, 1'b0};
        vecs[2] = '{2'd1, 6'd3,  8'h11, 8'h11, 1'b0, -1, 0, 2, 8'h0D, 8'h0D, 1'b1};
        vecs[3] = '{2'd1, 6'd3,  8'h11, 8'h11, 1'b0, -1, 0, 1, 8'h0D, 8'h0D, 1'b0};
        vecs[4] = '{2'd2, 6'd63, 8'h00, 8'h01, 1'b1, -1, 0, 0, 8'hFE, 8'hC1, 1'b0};
        vecs[5] = '{2'd0, 6'd1,  8'hA5, 8'h00, 1'b0,  0, 2, 0, 8'h04, 8'hA1, 1'b0};
        vecs[6] = '{2'd2, 6'd2,  8'hF0, 8'h01, 1'b0,  3, 3, 2, 8'h0A, 8'h0B, 1'b1};

        resetn = 1'b0; start = 1'b0; dest = '0; len = '0;
        src_data = '0; src_valid = 1'b0; busy = 1'b0; err = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_outs", {data_in, pkt_valid}, 9'h0);
        chk("reset_flags", {4'h0, src_ready, tx_busy, reject, done, pkt_err}, 9'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Refused requests: bad destination, then zero length
        for (int r = 0; r < 2; r++) begin
            dest = (r == 0) ? 2'd3 : 2'd1;
            len  = (r == 0) ? 6'd5 : 6'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("reject%0d_pulse", r), {6'h0, reject, tx_busy, pkt_valid}, 9'h4);
            @(negedge clk);
            chk($sformatf("reject%0d_end", r), {6'h0, reject, tx_busy, pkt_valid}, 9'h0);
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset during payload byte 0x22
        dest = 2'd1; len = 6'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1; src_data = 8'(8'h11 * (i + 1));
            @(negedge clk);
        end
        src_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre", {pkt_valid, data_in}, 9'h122);
        resetn = 1'b0;
        #1;
        chk("rst_async_data", {pkt_valid, data_in}, 9'h0);
        chk("rst_async_flags", {4'h0, src_ready, tx_busy, reject, done, pkt_err}, 9'h0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst_nodone%0d", i), {6'h0, done, pkt_valid, tx_busy}, 9'h0);
        end
        run_vec(vecs[0], 7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
